fetch_ctrl: RTL
===============

# fetch_ctrl

Sequencer for the instruction-fetch stage. Owns the architectural PC, issues reads to a variable-latency instruction memory, and presents one instruction per cycle to decode. Applies execute-stage redirects, decode back-pressure and HALT, and squashes in-flight fetches on redirect. Sits between the instruction memory and the IF/ID pipeline register.

## Interface
- RESET_PC, 16'h0000, PC loaded on reset
- NOP_INSTR, 16'h0800, encoding driven on instr_out when nothing valid
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- redirect_valid  in  1  execute resolved taken branch/jump this cycle
- redirect_pc  in  16  target PC, valid with redirect_valid
- stall_id  in  1  decode cannot accept instr_out this cycle
- halt  in  1  HALT decoded; freeze fetch
- imem_addr  out  16  read address (= pc)
- imem_rd  out  1  read request
- imem_stall  in  1  memory busy, request not accepted this cycle
- imem_done  in  1  imem_data valid this cycle
- imem_data  in  16  returned instruction
- imem_err  in  1  memory fault (unaligned/bad address)
- instr_out  out  16  fetched instruction to IF/ID
- pc_out  out  16  PC of instr_out
- pc_plus2  out  16  pc_out + 2, for link/branch base
- instr_valid  out  1  instr_out valid
- fetch_err  out  1  sticky fault flag

## Operation
- States: FETCH, WAIT, DRAIN, HALTED, ERR.
- FETCH: imem_rd=1 only when `!instr_valid || !stall_id`; otherwise hold request off.
  - If imem_stall: stay, re-present same address.
  - If accepted and imem_done the same cycle: capture.
  - If accepted without done: go to WAIT.
- WAIT: imem_rd=0; capture on imem_done, then return to FETCH.
- Capture:
  - Registers: instr_out<=imem_data, pc_out<=pc, instr_valid<=1, pc<=pc+2.
  - PC wraps modulo 2^16.
- Consumption: instr_valid && !stall_id with no capture this cycle gives instr_valid<=0 and instr_out<=NOP_INSTR.
- stall_id with instr_valid=1: instr_out and pc_out held unchanged.
- Event priority: rst_n > imem_err > redirect_valid > halt > stall_id.
- Redirect:
  - pc<=redirect_pc; instr_valid<=0; instr_out<=NOP_INSTR.
  - From WAIT: go to DRAIN, discard the next imem_done, then FETCH.
  - Redirect in DRAIN: updates pc and stays in DRAIN.
  - Redirect in the same cycle as a capture: data dropped, redirect wins.
- halt:
  - Go to HALTED and hold pc; imem_rd=0, instr_valid=0.
  - If in WAIT, the outstanding read is discarded.
  - Exit only via reset.
- imem_err: fetch_err<=1, go to ERR, imem_rd=0, instr_valid=0. Exit only via reset.

## Timing
- Reset state:
  - Asserted at a rising edge with rst_n=0: pc=RESET_PC, state=FETCH, instr_valid=0, instr_out=NOP_INSTR, pc_out=RESET_PC, fetch_err=0.
  - imem_rd forced 0 while rst_n=0.
  - Reset mid-WAIT abandons the read; a stale imem_done after reset is ignored only if it arrives in DRAIN. After reset the state is FETCH, so the memory must also be reset.
- imem_addr, imem_rd: combinational from state/pc. All other outputs registered.
- Zero-wait memory (done with rd): instr_valid rises the cycle after issue; throughput 1 instr/cycle.
- N-cycle memory: instr_valid rises 1 cycle after imem_done.
- Redirect to first valid instruction at the new target: 1 cycle plus memory latency from FETCH; from WAIT, the remaining old latency is added.
- pc_plus2 = pc_out + 16'd2, combinational.

## Structure
- fetch_ctrl_pkg:
  - state enum (FETCH, WAIT, DRAIN, HALTED, ERR).
  - NOP_INSTR default.
- PC incrementer reuses the existing cla_16b adder (a=pc, b=16'h0002, c_in=0).
- pc, instr_out and pc_out use the existing register module. No new sub-module.

## Test plan
- Reset, zero-wait memory returning 16'hA000+addr: instr_out sequence A000, A002, A004 with pc_out 0, 2, 4, instr_valid continuous from cycle 1.
- imem_stall high 3 cycles at pc=0x0004: imem_addr held 0x0004, pc does not advance, then normal fetch.
- 4-cycle memory, redirect_valid to 0x0100 during WAIT: old data discarded (DRAIN), next valid instr has pc_out=0x0100, no instruction from 0x0006 delivered.
- stall_id high 2 cycles with instr_valid=1: instr_out/pc_out unchanged, imem_rd=0, next instr delivered after release without skip or duplicate.
- halt at pc=0x0010: state HALTED, imem_rd=0, pc stays 0x0010 for 10 cycles; redirect ignored; rst_n low returns pc to RESET_PC.
- pc=0xFFFE fetch: next pc=0x0000; imem_err asserted: fetch_err=1 sticky, instr_valid=0 until reset.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Imported by fetch_ctrl.
package fetch_ctrl_pkg;

  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [15:0] PC_STEP   = 16'h0002;

  typedef enum logic [2:0] {
    FETCH,
    WAIT,
    DRAIN,
    HALTED,
    ERR
  } state_t;

endpackage

// File: rtl/cla_16b.sv
// 16-bit carry-lookahead adder built from generate/propagate terms.
// Shared arithmetic primitive.
module cla_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] sum
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c[0] = c_in;
    for (int i = 0; i < 16; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum = p ^ c[15:0];

endmodule

// File: rtl/register.sv
// Enabled register with synchronous active-low reset to a fixed value.
// Shared storage primitive.
module register #(
  parameter int          W   = 16,
  parameter logic [W-1:0] RST = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) q <= RST;
    else if (en) q <= d;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, talks to a variable-latency
// imem and hands one instruction per cycle to decode.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        stall_id,
  input  logic        halt,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic        imem_stall,
  input  logic        imem_done,
  input  logic [15:0] imem_data,
  input  logic        imem_err,
  output logic [15:0] instr_out,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2,
  output logic        instr_valid,
  output logic        fetch_err
);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d, pc_inc;
  logic [15:0] instr_d, pc_out_d;
  logic        valid_d, err_d;
  logic        capture;

  cla_16b u_pc_inc (
    .a    (pc_q),
    .b    (PC_STEP),
    .c_in (1'b0),
    .sum  (pc_inc)
  );

  // No request goes out in a cycle that will redirect, halt or fault.
  assign imem_addr = pc_q;
  assign imem_rd   = rst_n && (state_q == FETCH)
                   && (!instr_valid || !stall_id)
                   && !redirect_valid && !halt && !imem_err;

  assign capture = (state_q == FETCH && imem_rd && !imem_stall && imem_done)
                || (state_q == WAIT && imem_done);

  assign pc_plus2 = pc_out + 16'd2;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_out;
    pc_out_d = pc_out;
    valid_d  = instr_valid;
    err_d    = fetch_err;
    if (imem_err) begin
      err_d   = 1'b1;
      state_d = ERR;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (state_q == ERR || state_q == HALTED) begin
      state_d = state_q;
    end else if (redirect_valid) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      if (state_q != FETCH) state_d = DRAIN;
    end else if (halt) begin
      state_d = HALTED;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else begin
      if (instr_valid && !stall_id) begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
      if (capture) begin
        instr_d  = imem_data;
        pc_out_d = pc_q;
        valid_d  = 1'b1;
        pc_d     = pc_inc;
      end
      unique case (state_q)
        FETCH: if (imem_rd && !imem_stall && !imem_done) state_d = WAIT;
        WAIT:  if (imem_done) state_d = FETCH;
        DRAIN: if (imem_done) state_d = FETCH;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_valid <= valid_d;
      fetch_err   <= err_d;
    end
  end

  register #(.W(16), .RST(RESET_PC)) u_pc_reg (
    .clk (clk), .rst_n (rst_n), .en (1'b1), .d (pc_d), .q (pc_q)
  );

  register #(.W(16), .RST(NOP_INSTR)) u_instr_reg (
    .clk (clk), .rst_n (rst_n), .en (1'b1), .d (instr_d), .q (instr_out)
  );

  register #(.W(16), .RST(RESET_PC)) u_pc_out_reg (
    .clk (clk), .rst_n (rst_n), .en (1'b1), .d (pc_out_d), .q (pc_out)
  );

endmodule
